// File: rtl/irq_pkg.sv
// Shared types and constants for the four-source interrupt controller.
package irq_pkg;

  localparam int NSRC = 4;

  localparam logic [2:0] IRQ_PENDING = 3'd0;
  localparam logic [2:0] IRQ_MASK    = 3'd1;
  localparam logic [2:0] IRQ_MODE    = 3'd2;
  localparam logic [2:0] IRQ_FORCE   = 3'd3;
  localparam logic [2:0] IRQ_ACTIVE  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_GAP
  } irq_state_t;

  typedef logic [NSRC-1:0] irq_vec_t;
  typedef logic [1:0]      irq_idx_t;

  // Lowest set index wins; bit 0 is highest priority.
  function automatic irq_idx_t prio_idx(irq_vec_t r);
    prio_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (r[i]) prio_idx = irq_idx_t'(i);
    end
  endfunction

  function automatic irq_vec_t onehot(irq_idx_t i);
    onehot = irq_vec_t'(1) << i;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser with a trailing history flop for edge detection.
module irq_sync #(
  parameter int STAGES = 2,
  parameter int W      = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] s,
  output logic [W-1:0] p
);

  logic [W-1:0] chain [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      p <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      p <= chain[STAGES-1];
    end
  end

  assign s = chain[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: sync, edge/level qualify, pending/mask,
// fixed priority and a one-hot INT handshake with a forced gap.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  irq_in,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [3:0]  INT
);

  irq_vec_t   s, p;
  irq_vec_t   pending, mask, mode;
  irq_vec_t   clr, frc, pend_edge, pending_n, req;
  irq_idx_t   win, cur;
  irq_state_t state;
  irq_vec_t   int_q;
  logic       wr_pend, wr_mask, wr_mode, wr_frc;
  logic       unused_wdata;

  irq_sync #(
    .STAGES (SYNC_STAGES),
    .W      (NSRC)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (irq_in),
    .s   (s),
    .p   (p)
  );

  assign unused_wdata = ^wdata[31:4];

  assign wr_pend = we && (addr == IRQ_PENDING);
  assign wr_mask = we && (addr == IRQ_MASK);
  assign wr_mode = we && (addr == IRQ_MODE);
  assign wr_frc  = we && (addr == IRQ_FORCE);

  assign clr = wr_pend ? wdata[3:0] : '0;
  assign frc = wr_frc  ? wdata[3:0] : '0;

  // Set beats clear; level bits simply track s.
  assign pend_edge = (pending & ~clr) | (s & ~p) | frc;
  assign pending_n = (mode & s) | (~mode & pend_edge);

  assign req = pending & mask;
  assign win = prio_idx(req);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      mask    <= '0;
      mode    <= '0;
    end else begin
      pending <= pending_n;
      if (wr_mask) mask <= wdata[3:0];
      if (wr_mode) mode <= wdata[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cur   <= '0;
      int_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|req) begin
            cur   <= win;
            int_q <= onehot(win);
            state <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          if (!req[cur]) begin
            int_q <= '0;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          int_q <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign INT = int_q;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (addr == IRQ_PENDING): rdata[3:0] = pending;
      (addr == IRQ_MASK):    rdata[3:0] = mask;
      (addr == IRQ_MODE):    rdata[3:0] = mode;
      (addr == IRQ_ACTIVE):  rdata[3:0] = int_q;
      default:               rdata = '0;
    endcase
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller that sits directly upstream of the MIPS core and drives its 4-bit `INT` input. It synchronises four asynchronous request lines, edge- or level-qualifies them, latches pending state, and presents one masked, priority-resolved request at a time as a one-hot `INT` vector. A small word-addressed register port, decoded beside data memory on the core's store/load bus, gives software mask, mode, clear and force control.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth on `irq_in`. Legal values are 2 and 3; every latency below is for 2, and each extra stage adds one cycle.
- `clk`  in  1: single system clock, rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `irq_in`  in  4: asynchronous interrupt requests, active-high.
- `we`  in  1: register write strobe, sampled on `clk`.
- `addr`  in  3: register word address.
- `wdata`  in  32: write data; only bits [3:0] are used.
- `rdata`  out  32: combinational read data for `addr`. Bits [31:4] are always 0.
- `INT`  out  4: one-hot request to the core, registered. Either all zero or exactly one bit set.

## Operation
- **Registers** (bit i corresponds to source i; unused addresses read 0 and ignore writes):
  - 0 PENDING: read; write-1-to-clear, edge-mode bits only.
  - 1 MASK: read/write; 1 = enabled.
  - 2 MODE: read/write; 0 = edge, 1 = level.
  - 3 FORCE: write-only, reads 0; write-1 sets PENDING for edge-mode bits.
  - 4 ACTIVE: read-only; the current `INT` value.
- **Synchroniser:** each `irq_in` bit passes through a `SYNC_STAGES` flop chain, giving `s`, followed by one history flop, giving `p`.
- **Edge mode:** PENDING[i] is set when `s & ~p`, or on a FORCE write to bit i. It is cleared by a W1C write to PENDING.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- **Level mode:**
  - PENDING[i] is registered from `s` every cycle.
  - W1C and FORCE writes are ignored for that bit.
  - When MODE switches edge to level, PENDING takes `s` on the next edge.
- **Request:** `req = PENDING & MASK`. The winner is the lowest-index set bit of `req`, so bit 0 has the highest priority.
- **FSM** (states IDLE, ASSERT, GAP):
  - IDLE, `INT`=0: if `req` is nonzero, latch the winner index into `cur` and go to ASSERT.
  - ASSERT, `INT` = one-hot of `cur`: hold while `req[cur]`=1. When `req[cur]` falls (cleared, masked, or level dropped), go to GAP.
    - A new higher-priority request does **not** pre-empt; `cur` is held.
  - GAP, `INT`=0 for exactly one cycle: always go to IDLE. This gives the core a fresh rising edge for back-to-back requests.
- **Reset:** clears synchroniser flops, `p`, PENDING, MASK, MODE and `cur`; state goes to IDLE and `INT` to 4'b0000.
  - Reset during ASSERT drops `INT` on that edge.
  - Requests in flight in the synchroniser are discarded.

## Timing
- **Edge-mode latency:** call the first edge at which `irq_in` is high edge 1. `s` rises at edge 2, PENDING sets at edge 3, and `INT` asserts at edge 4 if the source is masked on and the FSM is in IDLE.
- **Register writes:** take effect at the write edge.
  - A W1C on `cur` lowers `req[cur]` after that edge.
  - `INT` falls at the following edge, entering GAP.
  - The next winner's `INT` rises two edges after that, via IDLE.
- **Force:** a FORCE write at edge n sets PENDING at n; `INT` rises at n+1 from IDLE.
- **Mask:** changes `req` immediately after the write edge, with no extra stage. Unmasking an already-pending bit asserts `INT` one edge after the write.
- **Level mode:** PENDING follows `s` with one cycle of lag. Level deassertion reaches `INT` 4 edges after `irq_in` falls.
- **Edge detection:** a pulse on `irq_in` shorter than one clock period may be missed; sources must hold for at least 2 cycles.

## Structure
- **Shared package `irq_pkg`:**
  - Register address constants: `IRQ_PENDING`=0, `IRQ_MASK`=1, `IRQ_MODE`=2, `IRQ_FORCE`=3, `IRQ_ACTIVE`=4.
  - FSM state encoding.
  - Source count, 4.
- **Sub-module `irq_sync`:** parameterised `SYNC_STAGES`-deep synchroniser plus history flop, instantiated once with width 4. It outputs `s` and `p`.
- **Inside `irq_ctrl`:** pending/mask/mode registers, priority encoder and FSM.

## Test plan
- **Edge path:** `rst`, write MASK=4'hF. Raise `irq_in[2]` for 3 cycles, then write PENDING=4'b0100.
  - `INT`=4'b0100 from edge 4.
  - `INT` goes to 0 one edge after the write.
  - PENDING reads 0.
- **Priority and no pre-emption:** MASK=4'hF. FORCE=4'b1000, then 2 cycles later FORCE=4'b0001.
  - `INT` stays 4'b1000 until PENDING=4'b1000 is cleared.
  - Then 1 cycle at 0, then `INT`=4'b0001.
- **Mask gating:** MASK=0, pulse `irq_in[1]`.
  - PENDING=4'b0010 and `INT`=0.
  - Writing MASK=4'b0010 gives `INT`=4'b0010 one edge later.
  - Writing MASK=0 drops `INT` through GAP.
- **Level mode and set-wins:**
  - Level: MODE=4'b0001, MASK=4'b0001. Hold `irq_in[0]` high, W1C bit 0: PENDING stays 1 and `INT` stays 4'b0001. Drop `irq_in[0]`: `INT` goes to 0 four edges later.
  - Set-wins: on an edge-mode bit, issue a W1C in the same cycle as a detected edge. PENDING remains 1.
- **Reset mid-operation:** with `INT`=4'b0100 and MASK=4'hF, assert `rst` for 1 cycle.
  - Next edge: `INT`=0, and PENDING, MASK and MODE read 0.
  - With no new stimulus, `INT` stays 0.
